// File: rtl/in_out_register_pkg.sv
// Shared constants and types for processor-visible registers.
//   DATA_W        : default data bus width
//   data_t        : one data-bus word
//   OUT_RESET_VAL : default reset value for output latches
package in_out_register_pkg;

  localparam int unsigned DATA_W = 8;

  typedef logic [DATA_W-1:0] data_t;

  localparam data_t OUT_RESET_VAL = '0;

endpackage : in_out_register_pkg

// File: rtl/in_out_register_sync_chain.sv
// WIDTH x STAGES flop chain for bringing asynchronous inputs into clk.
//   clk  : system clock
//   rst  : synchronous active-high reset, clears every stage
//   d_i  : asynchronous input word
//   q_o  : last stage of the chain (d_i directly when STAGES == 0)
module in_out_register_sync_chain #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (STAGES == 0) begin : g_bypass
    // Pure pass-through; clock and reset have no role here.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q_o = d_i;
  end else begin : g_chain
    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift chain: stage 0 samples the pins, each later stage follows the previous one.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(STAGES); i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < int'(STAGES); i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[STAGES-1];
  end

endmodule : in_out_register_sync_chain

// File: rtl/in_out_register.sv
// 8-bit processor I/O port: a writable output latch and a synchronized input.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   WEinOut : processor write enable for the output latch
//   dataIn  : processor data bus value to latch onto OUT
//   dataOut : synchronized IN value returned to the processor
//   IN      : external input pins, asynchronous to clk
//   OUT     : external output pins, straight from the latch register
module in_out_register
  import in_out_register_pkg::*;
#(
  parameter int unsigned      WIDTH       = DATA_W,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET   = WIDTH'(OUT_RESET_VAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WEinOut,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] OUT
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;

  // Output latch next-state: load on write enable, otherwise hold.
  always_comb begin
    out_d = out_q;
    if (WEinOut) begin
      out_d = dataIn;
    end
  end

  // Output latch register; reset takes priority over a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= OUT_RESET;
    end else begin
      out_q <= out_d;
    end
  end

  assign OUT = out_q;

  // Input path is fully independent of the latch and of WEinOut.
  in_out_register_sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (IN),
    .q_o (dataOut)
  );

endmodule : in_out_register

// File: tb/tb_in_out_register.sv
module tb_in_out_register;
  import in_out_register_pkg::*;

  localparam int unsigned S = 2;
  localparam data_t       OUT_RST = '0;

  logic  clk = 1'b0;
  logic  rst;
  logic  we;
  data_t data_in;
  data_t in_pins;
  data_t data_out;
  data_t out_pins;
  data_t data_out0;
  data_t out_pins0;

  int total = 0;
  int bad   = 0;

  // Reference model state: last value written, plus a log of IN per edge.
  data_t exp_out;
  int    edge_n   = 0;
  int    rst_edge = 0;
  data_t samp [int];

  always #5 clk = ~clk;

  in_out_register #(.WIDTH(DATA_W), .SYNC_STAGES(S), .OUT_RESET(OUT_RST)) dut (
    .clk(clk), .rst(rst), .WEinOut(we), .dataIn(data_in),
    .dataOut(data_out), .IN(in_pins), .OUT(out_pins)
  );

  in_out_register #(.WIDTH(DATA_W), .SYNC_STAGES(0), .OUT_RESET(OUT_RST)) dut0 (
    .clk(clk), .rst(rst), .WEinOut(we), .dataIn(data_in),
    .dataOut(data_out0), .IN(in_pins), .OUT(out_pins0)
  );

  // dataOut after edge n is the IN sampled S-1 edges earlier, or 0 if reset is too recent.
  function automatic data_t exp_dout();
    if (edge_n - rst_edge >= int'(S)) return samp[edge_n - int'(S) + 1];
    return '0;
  endfunction

  // One rising edge: advance the model on the sampled inputs, return at the falling edge.
  task automatic step();
    @(posedge clk);
    edge_n++;
    samp[edge_n] = in_pins;
    if (rst) begin
      exp_out  = OUT_RST;
      rst_edge = edge_n;
    end else if (we) begin
      exp_out = data_in;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b1; data_in = 8'd100; in_pins = 8'd100;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (out_pins !== 8'd0) begin
        bad++; $display("FAIL reset_out edge%0d: got %0d want 0", i, out_pins);
      end
      total++;
      if (data_out !== 8'd0) begin
        bad++; $display("FAIL reset_dout edge%0d: got %0d want 0", i, data_out);
      end
    end
  endtask

  task automatic test_write();
    rst = 1'b0; we = 1'b1; data_in = 8'd100;
    step();
    total++;
    if (out_pins !== 8'd100) begin
      bad++; $display("FAIL write_load: got %0d want 100", out_pins);
    end
    we = 1'b0; data_in = 8'd127;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (out_pins !== 8'd100) begin
        bad++; $display("FAIL write_hold edge%0d: got %0d want 100", i, out_pins);
      end
    end
  endtask

  task automatic test_read_latency();
    data_t vals [3];
    vals[0] = 8'd0; vals[1] = 8'd100; vals[2] = 8'd127;
    for (int v = 0; v < 3; v++) begin
      data_t prev;
      prev = data_out;
      in_pins = vals[v];
      for (int e = 1; e <= 4; e++) begin
        we = 1'($urandom_range(0, 1));
        data_in = data_t'($urandom);
        step();
        total++;
        if (e < int'(S) && data_out !== prev) begin
          bad++; $display("FAIL read_early val%0d edge%0d: got %0d want %0d", v, e, data_out, prev);
        end else if (e >= int'(S) && data_out !== vals[v]) begin
          bad++; $display("FAIL read_latency val%0d edge%0d: got %0d want %0d", v, e, data_out, vals[v]);
        end
        total++;
        if (out_pins !== exp_out) begin
          bad++; $display("FAIL read_out_model edge%0d: got %0d want %0d", e, out_pins, exp_out);
        end
      end
    end
    we = 1'b0;
  endtask

  task automatic test_priority();
    rst = 1'b0; we = 1'b1; data_in = 8'd100;
    step();
    total++;
    if (out_pins !== 8'd100) begin
      bad++; $display("FAIL prio_setup: got %0d want 100", out_pins);
    end
    rst = 1'b1; we = 1'b1; data_in = 8'd255;
    step();
    total++;
    if (out_pins !== 8'd0) begin
      bad++; $display("FAIL prio_reset_wins: got %0d want 0", out_pins);
    end
    total++;
    if (data_out !== 8'd0) begin
      bad++; $display("FAIL prio_sync_cleared: got %0d want 0", data_out);
    end
    rst = 1'b0; we = 1'b0;
  endtask

  task automatic test_independence();
    in_pins = 8'd0;
    for (int i = 0; i < 3; i++) step();
    we = 1'b1; data_in = 8'd127; in_pins = 8'd55;
    step();
    we = 1'b0;
    total++;
    if (out_pins !== 8'd127) begin
      bad++; $display("FAIL indep_out: got %0d want 127", out_pins);
    end
    step();
    total++;
    if (data_out !== 8'd55) begin
      bad++; $display("FAIL indep_dout: got %0d want 55", data_out);
    end
    total++;
    if (out_pins !== 8'd127) begin
      bad++; $display("FAIL indep_out_hold: got %0d want 127", out_pins);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst     = ($urandom_range(0, 24) == 0);
      we      = 1'($urandom_range(0, 1));
      data_in = data_t'($urandom);
      in_pins = data_t'($urandom);
      step();
      total++;
      if (out_pins !== exp_out) begin
        bad++; $display("FAIL rand_out cyc%0d: got %0d want %0d", i, out_pins, exp_out);
      end
      total++;
      if (data_out !== exp_dout()) begin
        bad++; $display("FAIL rand_dout cyc%0d: got %0d want %0d", i, data_out, exp_dout());
      end
      total++;
      if (out_pins0 !== exp_out) begin
        bad++; $display("FAIL rand_out0 cyc%0d: got %0d want %0d", i, out_pins0, exp_out);
      end
    end
    rst = 1'b0; we = 1'b0;
  endtask

  task automatic test_passthrough();
    data_t vals [2];
    vals[0] = 8'd100; vals[1] = 8'd127;
    for (int v = 0; v < 2; v++) begin
      in_pins = vals[v];
      #1;
      total++;
      if (data_out0 !== vals[v]) begin
        bad++; $display("FAIL passthru val%0d: got %0d want %0d", v, data_out0, vals[v]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      data_t r;
      r = data_t'($urandom);
      in_pins = r;
      #0.2;
      total++;
      if (data_out0 !== r) begin
        bad++; $display("FAIL passthru_rand %0d: got %0d want %0d", i, data_out0, r);
      end
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; data_in = '0; in_pins = '0;
    exp_out = OUT_RST;
    test_reset();
    test_write();
    test_read_latency();
    test_priority();
    test_independence();
    test_random();
    @(negedge clk);
    test_passthrough();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_in_out_register

// File: doc/in_out_register.md
Name: in_out_register

Overview:
- 8-bit processor I/O port block with two independent paths.
- Write path: a processor-writable output latch drives the external OUT pins.
- Read path: the external IN pins are synchronized and presented to the processor data bus as dataOut.
- Sits between the processor data bus / write-enable decode and the chip-level I/O pins.

Parameters:
- WIDTH, 8, data width of the bus and of both ports.
- SYNC_STAGES, 2, number of flops on the IN -> dataOut path. Legal range 0..4; 0 means a combinational pass-through.
- OUT_RESET, 0, value OUT takes on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- WEinOut  input  1  write enable for the output latch, from the processor.
- dataIn  input  WIDTH  processor data bus value to be written to OUT.
- dataOut  output  WIDTH  synchronized IN value returned to the processor.
- IN  input  WIDTH  external input pins; asynchronous to clk.
- OUT  output  WIDTH  external output pins; registered.

Interface note: one clock; reset is synchronous and active-high.

Behaviour:
- Reset, sampled on a rising clk edge with rst=1:
  - OUT <= OUT_RESET.
  - All synchronizer stages <= 0, so dataOut=0 after the edge when SYNC_STAGES>0.
  - Reset has priority over WEinOut.
- Output latch:
  - On a rising edge with rst=0 and WEinOut=1: OUT <= dataIn.
  - Latency: one edge; the new value is visible immediately after the edge.
  - With WEinOut=0, OUT holds its value indefinitely.
  - dataIn changes while WEinOut=0 have no effect.
  - OUT is driven directly from the register; there is no combinational path from dataIn to OUT.
- Input path:
  - IN feeds a shift chain of SYNC_STAGES flops; dataOut is the last stage.
  - Latency: a change on IN appears on dataOut after SYNC_STAGES rising edges.
  - SYNC_STAGES=0: dataOut = IN combinationally, with no reset effect.
  - The input path ignores WEinOut. OUT never feeds back into dataOut; the two paths are fully independent.
- Simultaneous events:
  - WEinOut=1 together with an IN change in the same cycle: both paths update independently.
  - rst=1 together with WEinOut=1: reset wins, so OUT=OUT_RESET.
- Reset mid-operation:
  - Any in-flight synchronizer data is discarded.
  - The first valid IN sample reaches dataOut SYNC_STAGES edges after rst deasserts.
- Widths: all data WIDTH bits; no truncation or extension; no arithmetic.
- X handling: with OUT_RESET defined, OUT is never X after the first reset edge.

Decomposition:
- Shared package: WIDTH default (data bus width constant), a data-word typedef, and the OUT reset constant. These are shared with other processor registers.
- One natural sub-module: sync_chain. It is a parameterized WIDTH x SYNC_STAGES flop chain with synchronous reset, and it is reused for other asynchronous inputs.
- The output latch stays inline in in_out_register.

Test Plan:
- Reset: assert rst for 2 edges with dataIn=100, WEinOut=1, IN=100 -> OUT=0 and dataOut=0 throughout reset.
- Write: rst=0, WEinOut=1, dataIn=100 for one edge -> OUT=100 after that edge. Then WEinOut=0, dataIn=127 -> OUT stays 100 over 10 edges.
- Read latency: IN steps 0 -> 100 -> 127 -> dataOut shows 100, then 127, each exactly SYNC_STAGES (=2) edges after the corresponding IN change. WEinOut toggling has no effect on dataOut.
- Priority: rst=1 and WEinOut=1 with dataIn=255 on the same edge, OUT previously 100 -> OUT=0.
- Independence: WEinOut=1, dataIn=127, and IN=55 set on the same edge -> OUT=127 after 1 edge; dataOut=55 after 2 edges; OUT never reflects IN.
- Pass-through: build with SYNC_STAGES=0, drive IN=100 then 127 with no clock -> dataOut follows IN immediately.
